// File: rtl/wb_spi_fifo.sv
// Wishbone register front-end with TX/RX byte FIFOs feeding an SPI shift engine.
// DATA pushes TX / pops RX, STATUS reports levels and sticky overflows, CONTROL flushes.
module wb_spi_fifo #(
  parameter logic [31:0] BASE_ADR = 32'h0100_0100,
  parameter int          DEPTH    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  input  logic        spi_busy_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] ADR_DATA = BASE_ADR;
  localparam logic [31:0] ADR_STAT = BASE_ADR + 32'd4;
  localparam logic [31:0] ADR_CTRL = BASE_ADR + 32'd8;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    tx_mem_q [DEPTH];
  logic [7:0]    rx_mem_q [DEPTH];
  logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [AW-1:0] tx_wr_d, tx_rd_d, rx_wr_d, rx_rd_d;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q, tx_cnt_d, rx_cnt_d;
  logic          tx_ovf_q, rx_ovf_q, tx_ovf_d, rx_ovf_d;
  logic          ack_q;
  logic [31:0]   dat_q;

  logic        req, acc_data, acc_stat, acc_ctrl, accept;
  logic        tx_full, rx_full, tx_empty, rx_empty;
  logic        tx_push_req, tx_push, tx_pop, tx_flush, tx_ovf_set;
  logic        rx_push_req, rx_push, rx_pop, rx_flush, rx_ovf_set;
  logic [31:0] status, rdata;
  logic        unused_bits;

  assign unused_bits = ^{wb_sel_i[3:1], wb_dat_i[31:8]};

  // Decode: a held strobe cannot be re-accepted while its ack is still out.
  assign req      = wb_cyc_i & wb_stb_i & ~ack_q;
  assign acc_data = req & (wb_adr_i == ADR_DATA);
  assign acc_stat = req & (wb_adr_i == ADR_STAT);
  assign acc_ctrl = req & (wb_adr_i == ADR_CTRL);
  assign accept   = acc_data | acc_stat | acc_ctrl;

  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_empty = (rx_cnt_q == '0);

  // A pop frees a slot in the same cycle, so push on full succeeds alongside it.
  assign tx_pop      = ~tx_empty & tx_ready_i;
  assign tx_flush    = acc_ctrl & wb_we_i & wb_dat_i[0];
  assign tx_push_req = acc_data & wb_we_i & wb_sel_i[0];
  assign tx_push     = tx_push_req & (~tx_full | tx_pop) & ~tx_flush;
  assign tx_ovf_set  = tx_push_req & tx_full & ~tx_pop & ~tx_flush;

  assign rx_pop      = acc_data & ~wb_we_i & ~rx_empty;
  assign rx_flush    = acc_ctrl & wb_we_i & wb_dat_i[1];
  assign rx_push_req = rx_valid_i;
  assign rx_push     = rx_push_req & (~rx_full | rx_pop) & ~rx_flush;
  assign rx_ovf_set  = rx_push_req & rx_full & ~rx_pop & ~rx_flush;

  always_comb begin
    status        = '0;
    status[0]     = tx_empty;
    status[1]     = tx_full;
    status[2]     = rx_empty;
    status[3]     = rx_full;
    status[4]     = tx_ovf_q;
    status[5]     = rx_ovf_q;
    status[6]     = tx_empty & ~spi_busy_i;
    status[15:8]  = 8'(tx_cnt_q);
    status[23:16] = 8'(rx_cnt_q);
  end

  always_comb begin
    rdata = '0;
    if (acc_data & ~wb_we_i & ~rx_empty) rdata = {23'b0, 1'b1, rx_mem_q[rx_rd_q]};
    else if (acc_stat & ~wb_we_i)        rdata = status;
  end

  always_comb begin
    tx_wr_d  = tx_push ? tx_wr_q + AW'(1) : tx_wr_q;
    tx_rd_d  = tx_pop  ? tx_rd_q + AW'(1) : tx_rd_q;
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    if (tx_flush) begin
      tx_wr_d  = '0;
      tx_rd_d  = '0;
      tx_cnt_d = '0;
    end
    rx_wr_d  = rx_push ? rx_wr_q + AW'(1) : rx_wr_q;
    rx_rd_d  = rx_pop  ? rx_rd_q + AW'(1) : rx_rd_q;
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    if (rx_flush) begin
      rx_wr_d  = '0;
      rx_rd_d  = '0;
      rx_cnt_d = '0;
    end
    // W1C clear first, so a same-cycle overflow keeps the flag set.
    tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~(acc_stat & wb_we_i & wb_dat_i[4]));
    rx_ovf_d = rx_ovf_set | (rx_ovf_q & ~(acc_stat & wb_we_i & wb_dat_i[5]));
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      if (tx_push) tx_mem_q[tx_wr_q] <= wb_dat_i[7:0];
      if (rx_push) rx_mem_q[rx_wr_q] <= rx_data_i;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      ack_q    <= accept;
      dat_q    <= rdata;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign tx_valid_o = ~tx_empty;
  assign tx_data_o  = tx_mem_q[tx_rd_q];

endmodule

// File: tb/tb_wb_spi_fifo.sv
// Bench for wb_spi_fifo: queue-based model checked every cycle plus directed
// register reads compared against hand-computed values.
module tb_wb_spi_fifo;
  localparam logic [31:0] BASE  = 32'h0100_0100;
  localparam int          DEPTH = 8;

  logic        clk, rst_n;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready, rx_valid, spi_busy;
  logic [7:0]  rx_data;

  int checks = 0;
  int errors = 0;

  wb_spi_fifo #(.BASE_ADR(BASE), .DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o), .tx_valid_o(tx_valid_o),
    .tx_data_o(tx_data_o), .tx_ready_i(tx_ready), .rx_valid_i(rx_valid),
    .rx_data_i(rx_data), .spi_busy_i(spi_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Model: two byte queues, two sticky flags, and the pending bus response.
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  bit          m_txovf = 1'b0, m_rxovf = 1'b0, m_ack = 1'b0;
  logic [31:0] m_dat = '0;

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (txq.size() == 0);
    s[1]     = (txq.size() == DEPTH);
    s[2]     = (rxq.size() == 0);
    s[3]     = (rxq.size() == DEPTH);
    s[4]     = m_txovf;
    s[5]     = m_rxovf;
    s[6]     = (txq.size() == 0) && !spi_busy;
    s[15:8]  = 8'(txq.size());
    s[23:16] = 8'(rxq.size());
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic acc, txpop, rxpop;
    logic [31:0] rd;
    if (!rst_n) begin
      txq.delete();
      rxq.delete();
      m_txovf = 1'b0;
      m_rxovf = 1'b0;
      m_ack   = 1'b0;
      m_dat   = '0;
    end else begin
      acc = cyc && stb && !m_ack && (adr == BASE || adr == BASE + 4 || adr == BASE + 8);
      rd  = '0;
      if (acc && !we) begin
        if (adr == BASE && rxq.size() > 0) rd = {23'b0, 1'b1, rxq[0]};
        else if (adr == BASE + 4)          rd = model_status();
      end
      txpop = (txq.size() > 0) && tx_ready;
      rxpop = acc && !we && adr == BASE && rxq.size() > 0;
      if (acc && we && adr == BASE + 4) begin
        if (wdat[4]) m_txovf = 1'b0;
        if (wdat[5]) m_rxovf = 1'b0;
      end
      if (txpop) void'(txq.pop_front());
      if (acc && we && adr == BASE + 8 && wdat[0]) txq.delete();
      else if (acc && we && adr == BASE && sel[0]) begin
        if (txq.size() < DEPTH) txq.push_back(wdat[7:0]);
        else m_txovf = 1'b1;
      end
      if (rxpop) void'(rxq.pop_front());
      if (acc && we && adr == BASE + 8 && wdat[1]) rxq.delete();
      else if (rx_valid) begin
        if (rxq.size() < DEPTH) rxq.push_back(rx_data);
        else m_rxovf = 1'b1;
      end
      m_ack = acc;
      m_dat = rd;
    end
  end

  always @(negedge clk) begin
    chk("ack", {31'b0, wb_ack_o}, {31'b0, m_ack});
    chk("dat", wb_dat_o, m_dat);
    chk("tx_valid", {31'b0, tx_valid_o}, {31'b0, txq.size() != 0});
    if (txq.size() != 0) chk("tx_data", {24'b0, tx_data_o}, {24'b0, txq[0]});
  end

  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    int n;
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; wdat = d; sel = s;
    n = 0; r = '0;
    do begin
      @(posedge clk); #1; n++;
    end while (!wb_ack_o && n < 20);
    checks++;
    if (!wb_ack_o) begin
      errors++;
      $display("FAIL ack_timeout adr %h got no ack required ack", a);
    end else r = wb_dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(a, 1'b1, d, 4'h1, r);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    wb_xfer(a, 1'b0, 32'h0, 4'hf, r);
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic tx_pulse();
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
  endtask

  logic [31:0] r;
  int n;

  initial begin
    rst_n = 1'b1; adr = '0; wdat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; spi_busy = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_tx_valid", {31'b0, tx_valid_o}, 32'h0);
    chk("rst_tx_data", {24'b0, tx_data_o}, 32'h0);
    chk("rst_ack", {31'b0, wb_ack_o}, 32'h0);
    @(posedge clk); #1;

    wb_read(BASE + 4, r);     chk("stat_reset", r, 32'h0000_0045);
    spi_busy = 1'b1;
    wb_read(BASE + 4, r);     chk("stat_busy", r, 32'h0000_0005);
    spi_busy = 1'b0;
    wb_read(BASE + 8, r);     chk("ctrl_read", r, 32'h0);
    wb_xfer(BASE, 1'b1, 32'h99, 4'h0, r);
    wb_read(BASE + 4, r);     chk("stat_sel0", r, 32'h0000_0045);

    wb_write(BASE, 32'hA5);
    wb_write(BASE, 32'h3C);
    wb_read(BASE + 4, r);     chk("stat_two", r, 32'h0000_0204);
    chk("head_a5", {24'b0, tx_data_o}, 32'hA5);
    tx_pulse();
    chk("head_3c", {24'b0, tx_data_o}, 32'h3C);
    tx_pulse();
    chk("drained", {31'b0, tx_valid_o}, 32'h0);

    for (int i = 0; i < 9; i++) wb_write(BASE, 32'h50 + i);
    wb_read(BASE + 4, r);     chk("stat_txovf", r, 32'h0000_0816);
    wb_write(BASE + 4, 32'h10);
    wb_read(BASE + 4, r);     chk("stat_txw1c", r, 32'h0000_0806);
    wb_write(BASE + 8, 32'h1);
    wb_read(BASE + 4, r);     chk("stat_txflush", r, 32'h0000_0045);

    rx_pulse(8'h11);
    rx_pulse(8'h22);
    wb_read(BASE + 4, r);     chk("stat_rx2", r, 32'h0002_0041);
    wb_read(BASE, r);         chk("rx_rd1", r, 32'h111);
    wb_read(BASE, r);         chk("rx_rd2", r, 32'h122);
    wb_read(BASE, r);         chk("rx_rd3", r, 32'h000);
    wb_read(BASE + 4, r);     chk("stat_rx0", r, 32'h0000_0045);

    for (int i = 1; i <= 8; i++) rx_pulse(8'(i));
    cyc = 1'b1; stb = 1'b1; adr = BASE; we = 1'b0; sel = 4'hf;
    rx_valid = 1'b1; rx_data = 8'h77;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    chk("simul_ack", {31'b0, wb_ack_o}, 32'h1);
    chk("simul_dat", wb_dat_o, 32'h101);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    wb_read(BASE + 4, r);     chk("stat_rxfull", r, 32'h0008_0049);
    for (int i = 0; i < 8; i++) wb_read(BASE, r);
    chk("rx_last77", r, 32'h177);

    for (int i = 0; i < 8; i++) rx_pulse(8'h30 + 8'(i));
    cyc = 1'b1; stb = 1'b1; adr = BASE + 4; we = 1'b1; wdat = 32'h20; sel = 4'h1;
    rx_valid = 1'b1; rx_data = 8'hEE;
    @(posedge clk); #1;
    rx_valid = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    wb_read(BASE + 4, r);     chk("stat_setwins", r, 32'h0008_0069);
    wb_write(BASE + 4, 32'h20);
    wb_read(BASE + 4, r);     chk("stat_rxw1c", r, 32'h0008_0049);
    wb_write(BASE + 8, 32'h2);
    wb_read(BASE + 4, r);     chk("stat_rxflush", r, 32'h0000_0045);

    for (int i = 0; i < 3; i++) wb_write(BASE, 32'h61 + i);
    rx_pulse(8'hA1);
    rx_pulse(8'hA2);
    wb_read(BASE + 4, r);     chk("stat_preflush", r, 32'h0002_0300);
    wb_write(BASE + 8, 32'h3);
    wb_read(BASE + 4, r);     chk("stat_flush", r, 32'h0000_0045);

    cyc = 1'b1; stb = 1'b1; adr = BASE + 12; we = 1'b0;
    n = 0;
    repeat (16) begin
      @(posedge clk); #1;
      if (wb_ack_o) n++;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("misadr_noack", n, 0);

    for (int i = 0; i < 5; i++) wb_write(BASE, 32'hC0 + i);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("middrain_valid", {31'b0, tx_valid_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("async_drop", {31'b0, tx_valid_o}, 32'h0);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", {31'b0, tx_valid_o}, 32'h0);
    wb_read(BASE + 4, r);     chk("stat_postrst", r, 32'h0000_0045);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
